// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: instruction fields and memory handshake in,
// datapath/memory/PC controls and debug status out.
interface mc_control_unit_if #(
   parameter int unsigned ALUOP_W = 3
);
   logic [5:0]         instr_op;
   logic [5:0]         instr_funct;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic [1:0]         pc_src;
   logic               ir_write;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic [1:0]         mem_to_reg;
   logic [1:0]         reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic               imm_zext;
   logic [ALUOP_W-1:0] alu_op;
   logic               instr_done;
   logic               fault;
   logic [3:0]         state_o;

   modport master (
      input  instr_op, instr_funct, mem_ready,
      output pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op,
             instr_done, fault, state_o
   );

   modport slave (
      output instr_op, instr_funct, mem_ready,
      input  pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op,
             instr_done, fault, state_o
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with memory wait states, timeout and illegal-op fault.
// Optional jal support is enabled by defining CU_JAL_EN.
module mc_control_unit #(
   parameter int unsigned ALUOP_W     = 3,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned TMO_W       = 5
) (
   input logic               clk,
   input logic               rst,
   mc_control_unit_if.master ctrl_io
);

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StExecR  = 4'd3,
      StWbR    = 4'd4,
      StExecI  = 4'd5,
      StWbI    = 4'd6,
      StAddr   = 4'd7,
      StMemRd  = 4'd8,
      StWbLd   = 4'd9,
      StMemWr  = 4'd10,
      StBranch = 4'd11,
      StJr     = 4'd12,
      StJal    = 4'd13,
      StFault  = 4'd15
   } state_e;

   localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(3'b110);
   localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(3'b111);
   localparam logic [ALUOP_W-1:0] AluNor = ALUOP_W'(3'b100);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
`ifdef CU_JAL_EN
   localparam logic [5:0] OpJal   = 6'b000011;
`endif
   localparam logic [5:0] FnAdd   = 6'b100000;
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnNor   = 6'b100111;
   localparam logic [5:0] FnSlt   = 6'b101010;
   localparam logic [5:0] FnJr    = 6'b001000;

   state_e             state_q, state_d;
   logic [TMO_W-1:0]   cnt_q, cnt_d;
   logic               tmo_hit;
   logic [TMO_W-1:0]   cnt_inc;

   logic               pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
   logic               reg_write, alu_src_a, imm_zext, instr_done, fault;
   logic [1:0]         pc_src, mem_to_reg, reg_dst, alu_src_b;
   logic [ALUOP_W-1:0] alu_op;

   // Wait-cycle budget: the TIMEOUT_CYC-th consecutive not-ready cycle is the last one.
   assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == TMO_W'(TIMEOUT_CYC - 1));
   assign cnt_inc = (TIMEOUT_CYC != 0) ? cnt_q + TMO_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 2'b00;
      reg_dst       = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      imm_zext      = 1'b0;
      alu_op        = AluAnd;
      instr_done    = 1'b0;
      fault         = 1'b0;

      unique case (state_q)
         StIdle: state_d = StFetch;

         StFetch: begin
            mem_read = 1'b1;
            if (ctrl_io.mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               alu_src_b = 2'b01;
               alu_op    = AluAdd;
               state_d   = StDecode;
            end else if (tmo_hit) begin
               state_d = StFault;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         StDecode: begin
            // Speculatively compute the branch target into ALUOut.
            alu_src_b = 2'b11;
            alu_op    = AluAdd;
            case (ctrl_io.instr_op)
               OpRtype: begin
                  case (ctrl_io.instr_funct)
                     FnAdd, FnAnd, FnNor, FnSlt: state_d = StExecR;
                     FnJr:                       state_d = StJr;
                     default:                    state_d = StFault;
                  endcase
               end
               OpAddi, OpAndi: state_d = StExecI;
               OpLw, OpSw:     state_d = StAddr;
               OpBeq:          state_d = StBranch;
`ifdef CU_JAL_EN
               OpJal:          state_d = StJal;
`endif
               default:        state_d = StFault;
            endcase
         end

         StExecR: begin
            alu_src_a = 1'b1;
            case (ctrl_io.instr_funct)
               FnAnd:   alu_op = AluAnd;
               FnNor:   alu_op = AluNor;
               FnSlt:   alu_op = AluSlt;
               default: alu_op = AluAdd;
            endcase
            state_d = StWbR;
         end

         StWbR: begin
            reg_dst    = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end

         StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (ctrl_io.instr_op == OpAndi) begin
               alu_op   = AluAnd;
               imm_zext = 1'b1;
            end else begin
               alu_op = AluAdd;
            end
            state_d = StWbI;
         end

         StWbI: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end

         StAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = AluAdd;
            state_d   = (ctrl_io.instr_op == OpLw) ? StMemRd : StMemWr;
         end

         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (ctrl_io.mem_ready) begin
               state_d = StWbLd;
            end else if (tmo_hit) begin
               state_d = StFault;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         StWbLd: begin
            mem_to_reg = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end

         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (ctrl_io.mem_ready) begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end else if (tmo_hit) begin
               state_d = StFault;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = AluSub;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            instr_done    = 1'b1;
            state_d       = StFetch;
         end

         StJr: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_d    = StFetch;
         end

`ifdef CU_JAL_EN
         StJal: begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
`endif

         StFault: fault = 1'b1;

         default: state_d = StIdle;
      endcase
   end

   assign ctrl_io.pc_write      = pc_write;
   assign ctrl_io.pc_write_cond = pc_write_cond;
   assign ctrl_io.pc_src        = pc_src;
   assign ctrl_io.ir_write      = ir_write;
   assign ctrl_io.i_or_d        = i_or_d;
   assign ctrl_io.mem_read      = mem_read;
   assign ctrl_io.mem_write     = mem_write;
   assign ctrl_io.mem_to_reg    = mem_to_reg;
   assign ctrl_io.reg_dst       = reg_dst;
   assign ctrl_io.reg_write     = reg_write;
   assign ctrl_io.alu_src_a     = alu_src_a;
   assign ctrl_io.alu_src_b     = alu_src_b;
   assign ctrl_io.imm_zext      = imm_zext;
   assign ctrl_io.alu_op        = alu_op;
   assign ctrl_io.instr_done    = instr_done;
   assign ctrl_io.fault         = fault;
   assign ctrl_io.state_o       = state_q;

endmodule
